// File: rtl/mem_lsu_if.sv
// Bus channel between the load/store unit (master) and the data memory or bridge (slave).
interface mem_lsu_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: decodes memory ops, runs one registered bus access at a time,
// aligns load data for writeback and tracks the LL/SC link bit.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [5:0]  stall,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        adel_o,
    output logic        ades_o,
    mem_lsu_if.master   bus
);
    localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
    localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
    localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
    localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
    localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
    localparam logic [7:0] EXE_LL_OP  = 8'b11110000;
    localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
    localparam logic [7:0] EXE_SC_OP  = 8'b11111000;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;

    state_t      r_state;
    logic        r_bus_req, r_bus_we, r_llbit;
    logic [31:0] r_bus_addr, r_bus_wdata, r_rdata;
    logic [3:0]  r_bus_sel;

    logic        w_is_load, w_is_store, w_is_ll, w_is_sc, w_unsigned;
    logic [1:0]  w_size;
    logic        w_mem_op, w_misalign, w_sc_fail, w_start;
    logic [3:0]  w_sel;
    logic [31:0] w_store_data, w_rdata_src, w_byte_shift, w_result;
    logic [15:0] w_half;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_ll    = 1'b0;
        w_is_sc    = 1'b0;
        w_unsigned = 1'b0;
        w_size     = 2'd2;
        case (aluop_i)
            EXE_LB_OP:  begin w_is_load = 1'b1; w_size = 2'd0; end
            EXE_LBU_OP: begin w_is_load = 1'b1; w_size = 2'd0; w_unsigned = 1'b1; end
            EXE_LH_OP:  begin w_is_load = 1'b1; w_size = 2'd1; end
            EXE_LHU_OP: begin w_is_load = 1'b1; w_size = 2'd1; w_unsigned = 1'b1; end
            EXE_LW_OP:  w_is_load = 1'b1;
            EXE_LL_OP:  begin w_is_load = 1'b1; w_is_ll = 1'b1; end
            EXE_SB_OP:  begin w_is_store = 1'b1; w_size = 2'd0; end
            EXE_SH_OP:  begin w_is_store = 1'b1; w_size = 2'd1; end
            EXE_SW_OP:  w_is_store = 1'b1;
            EXE_SC_OP:  begin w_is_store = 1'b1; w_is_sc = 1'b1; end
            default: ;
        endcase
    end

    assign w_mem_op   = w_is_load | w_is_store;
    assign w_misalign = ((w_size == 2'd1) & mem_addr_i[0]) |
                        ((w_size == 2'd2) & (|mem_addr_i[1:0]));
    assign adel_o     = w_is_load  & w_misalign;
    assign ades_o     = w_is_store & w_misalign;
    assign w_sc_fail  = w_is_sc & ~r_llbit;
    assign w_start    = (r_state == IDLE) & w_mem_op & ~w_misalign & ~flush & ~w_sc_fail;

    // Big-endian lanes: sel bit 3 and data bits 31:24 belong to byte offset 0.
    always_comb begin
        case (w_size)
            2'd0:    w_sel = 4'b1000 >> mem_addr_i[1:0];
            2'd1:    w_sel = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            default: w_sel = 4'b1111;
        endcase
        case (w_size)
            2'd0:    w_store_data = {4{reg2_i[7:0]}};
            2'd1:    w_store_data = {2{reg2_i[15:0]}};
            default: w_store_data = reg2_i;
        endcase
    end

    assign w_rdata_src  = (r_state == HOLD) ? r_rdata : bus.bus_rdata_i;
    assign w_byte_shift = w_rdata_src << {mem_addr_i[1:0], 3'b000};
    assign w_half       = mem_addr_i[1] ? w_rdata_src[15:0] : w_rdata_src[31:16];

    always_comb begin
        w_result = wdata_i;
        if (w_is_sc) begin
            w_result = 32'd1;
        end else if (w_is_load) begin
            case (w_size)
                2'd0:    w_result = {{24{~w_unsigned & w_byte_shift[31]}}, w_byte_shift[31:24]};
                2'd1:    w_result = {{16{~w_unsigned & w_half[15]}}, w_half};
                default: w_result = w_rdata_src;
            endcase
        end
    end

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        stallreq_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_op) begin
                    if (w_misalign || flush) begin
                        wreg_o = 1'b0;
                    end else if (w_sc_fail) begin
                        wdata_o = 32'd0;
                        wreg_o  = 1'b1;
                    end else begin
                        stallreq_o = 1'b1;
                        wreg_o     = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    wreg_o = 1'b0;
                end else if (bus.bus_ack_i) begin
                    wdata_o = w_result;
                    wreg_o  = w_is_load | w_is_sc;
                end else begin
                    stallreq_o = 1'b1;
                    wreg_o     = 1'b0;
                end
            end
            HOLD: begin
                wdata_o = w_result;
                wreg_o  = (w_is_load | w_is_sc) & ~flush;
            end
            default: wreg_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_sel   <= 4'b0000;
            r_bus_wdata <= 32'd0;
            r_rdata     <= 32'd0;
            r_llbit     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= w_is_store;
                        r_bus_addr  <= {mem_addr_i[31:2], 2'b00};
                        r_bus_sel   <= w_sel;
                        r_bus_wdata <= w_store_data;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        r_bus_req <= 1'b0;
                        r_state   <= bus.bus_ack_i ? IDLE : DRAIN;
                    end else if (bus.bus_ack_i) begin
                        r_bus_req <= 1'b0;
                        r_rdata   <= bus.bus_rdata_i;
                        if (w_is_ll) r_llbit <= 1'b1;
                        r_state   <= stall[4] ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (!stall[4] || flush) r_state <= IDLE;
                end
                DRAIN: begin
                    if (bus.bus_ack_i) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            // Placed last so a flush wins over an LL completing in the same cycle.
            if (flush) r_llbit <= 1'b0;
        end
    end

    assign bus.bus_req_o   = r_bus_req;
    assign bus.bus_we_o    = r_bus_we;
    assign bus.bus_addr_o  = r_bus_addr;
    assign bus.bus_sel_o   = r_bus_sel;
    assign bus.bus_wdata_o = r_bus_wdata;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: the bench plays the bus slave and checks every access by hand-computed values.
module tb_mem_lsu;
    localparam logic [7:0] NOP   = 8'h00;
    localparam logic [7:0] OP_LB  = 8'b11100000;
    localparam logic [7:0] OP_LBU = 8'b11100100;
    localparam logic [7:0] OP_LH  = 8'b11100001;
    localparam logic [7:0] OP_LHU = 8'b11100101;
    localparam logic [7:0] OP_LW  = 8'b11100011;
    localparam logic [7:0] OP_LL  = 8'b11110000;
    localparam logic [7:0] OP_SH  = 8'b11101001;
    localparam logic [7:0] OP_SW  = 8'b11101011;
    localparam logic [7:0] OP_SC  = 8'b11111000;
    localparam logic [31:0] WDATA_I = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  stall = 6'd0;
    logic [7:0]  aluop_i = NOP;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] reg2_i = 32'd0;
    logic [4:0]  wd_i = 5'd9;
    logic        wreg_i = 1'b1;
    logic [31:0] wdata_i = WDATA_I;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o, adel_o, ades_o;

    int n_checks = 0;
    int n_fail = 0;

    mem_lsu_if bus_if();

    mem_lsu dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq_o(stallreq_o), .adel_o(adel_o), .ades_o(ades_o),
        .bus(bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete access: issue, wait dly cycles for ack, check result cycle, return to IDLE.
    task automatic mem_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input int dly, input logic [31:0] rdata,
                          input logic [3:0] exp_sel, input logic exp_we, input logic [31:0] exp_bwd,
                          input logic [31:0] exp_res, input logic exp_wreg);
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wreg_i = ~exp_we;
        #1;
        check({tag, "_stall_pre"}, {31'd0, stallreq_o}, 32'd1);
        check({tag, "_wreg_pre"}, {31'd0, wreg_o}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_req"}, {31'd0, bus_if.bus_req_o}, 32'd1);
        check({tag, "_sel"}, {28'd0, bus_if.bus_sel_o}, {28'd0, exp_sel});
        check({tag, "_we"}, {31'd0, bus_if.bus_we_o}, {31'd0, exp_we});
        check({tag, "_addr"}, bus_if.bus_addr_o, {addr[31:2], 2'b00});
        if (exp_we) check({tag, "_bwdata"}, bus_if.bus_wdata_o, exp_bwd);
        for (int i = 1; i < dly; i++) begin
            @(posedge clk); #1;
            check({tag, "_stall_wait"}, {31'd0, stallreq_o}, 32'd1);
            check({tag, "_req_hold"}, {31'd0, bus_if.bus_req_o}, 32'd1);
        end
        bus_if.bus_ack_i = 1'b1; bus_if.bus_rdata_i = rdata;
        #1;
        check({tag, "_stall_ack"}, {31'd0, stallreq_o}, 32'd0);
        check({tag, "_res"}, wdata_o, exp_res);
        check({tag, "_wreg"}, {31'd0, wreg_o}, {31'd0, exp_wreg});
        @(posedge clk); #1;
        bus_if.bus_ack_i = 1'b0; aluop_i = NOP; wreg_i = 1'b1;
        check({tag, "_req_done"}, {31'd0, bus_if.bus_req_o}, 32'd0);
        $display("access %s op=%02h addr=%08h result=%08h", tag, op, addr, exp_res);
    endtask

    initial begin
        bus_if.bus_ack_i = 1'b0;
        bus_if.bus_rdata_i = 32'd0;
        #2 rst = 1'b1;
        #1;
        check("rst_req", {31'd0, bus_if.bus_req_o}, 32'd0);
        check("rst_we", {31'd0, bus_if.bus_we_o}, 32'd0);
        check("rst_addr", bus_if.bus_addr_o, 32'd0);
        check("rst_sel", {28'd0, bus_if.bus_sel_o}, 32'd0);
        check("rst_wdata", bus_if.bus_wdata_o, 32'd0);
        @(negedge clk); @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Non-memory op passes straight through.
        aluop_i = NOP; #1;
        check("nop_wd", {27'd0, wd_o}, 32'd9);
        check("nop_wreg", {31'd0, wreg_o}, 32'd1);
        check("nop_wdata", wdata_o, WDATA_I);
        check("nop_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
        check("nop_req", {31'd0, bus_if.bus_req_o}, 32'd0);

        mem_op("lw",  OP_LW,  32'h10, 32'd0, 3, 32'hDEADBEEF, 4'b1111, 1'b0, 32'd0, 32'hDEADBEEF, 1'b1);
        mem_op("lb",  OP_LB,  32'h01, 32'd0, 1, 32'h12803456, 4'b0100, 1'b0, 32'd0, 32'hFFFFFF80, 1'b1);
        mem_op("lbu", OP_LBU, 32'h01, 32'd0, 2, 32'h12803456, 4'b0100, 1'b0, 32'd0, 32'h00000080, 1'b1);
        mem_op("lh",  OP_LH,  32'h02, 32'd0, 1, 32'h12348001, 4'b0011, 1'b0, 32'd0, 32'hFFFF8001, 1'b1);
        mem_op("lhu", OP_LHU, 32'h00, 32'd0, 1, 32'h80011234, 4'b1100, 1'b0, 32'd0, 32'h00008001, 1'b1);
        mem_op("sh",  OP_SH,  32'h02, 32'h0000BEEF, 2, 32'd0, 4'b0011, 1'b1, 32'hBEEFBEEF, WDATA_I, 1'b0);

        // Misaligned word load and store.
        aluop_i = OP_LW; mem_addr_i = 32'h2; #1;
        check("adel_flag", {31'd0, adel_o}, 32'd1);
        check("adel_stall", {31'd0, stallreq_o}, 32'd0);
        check("adel_wreg", {31'd0, wreg_o}, 32'd0);
        @(posedge clk); #1;
        check("adel_req", {31'd0, bus_if.bus_req_o}, 32'd0);
        aluop_i = OP_SW; mem_addr_i = 32'h1; #1;
        check("ades_flag", {31'd0, ades_o}, 32'd1);
        check("ades_adel", {31'd0, adel_o}, 32'd0);
        @(posedge clk); #1;
        check("ades_req", {31'd0, bus_if.bus_req_o}, 32'd0);

        // SC with no link.
        aluop_i = OP_SC; mem_addr_i = 32'h20; reg2_i = 32'h77; #1;
        check("scfail_wdata", wdata_o, 32'd0);
        check("scfail_wreg", {31'd0, wreg_o}, 32'd1);
        check("scfail_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
        check("scfail_req", {31'd0, bus_if.bus_req_o}, 32'd0);
        aluop_i = NOP;

        mem_op("ll", OP_LL, 32'h20, 32'd0, 1, 32'h00000011, 4'b1111, 1'b0, 32'd0, 32'h00000011, 1'b1);
        mem_op("sc", OP_SC, 32'h20, 32'h77, 2, 32'd0, 4'b1111, 1'b1, 32'h77, 32'd1, 1'b1);

        // Ack while MEM/WB stalled: result must persist through HOLD.
        aluop_i = OP_LW; mem_addr_i = 32'h4;
        @(posedge clk); #1;
        stall = 6'b010000; bus_if.bus_ack_i = 1'b1; bus_if.bus_rdata_i = 32'hCAFEF00D; #1;
        check("hold_ackres", wdata_o, 32'hCAFEF00D);
        @(posedge clk); #1;
        bus_if.bus_ack_i = 1'b0; bus_if.bus_rdata_i = 32'h0; #1;
        check("hold_res", wdata_o, 32'hCAFEF00D);
        check("hold_wreg", {31'd0, wreg_o}, 32'd1);
        check("hold_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
        check("hold_noreq", {31'd0, bus_if.bus_req_o}, 32'd0);
        stall = 6'd0;
        @(posedge clk); #1;
        aluop_i = NOP;
        check("hold_exit_req", {31'd0, bus_if.bus_req_o}, 32'd0);
        $display("access hold op=%02h addr=%08h result=%08h", OP_LW, 32'h4, 32'hCAFEF00D);

        // Link, then flush an in-flight load: DRAIN until ack, link cleared.
        mem_op("ll2", OP_LL, 32'h20, 32'd0, 1, 32'h22, 4'b1111, 1'b0, 32'd0, 32'h22, 1'b1);
        aluop_i = OP_LW; mem_addr_i = 32'h8;
        @(posedge clk); #1;
        check("fl_req_on", {31'd0, bus_if.bus_req_o}, 32'd1);
        flush = 1'b1; #1;
        check("fl_wreg", {31'd0, wreg_o}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_req_off", {31'd0, bus_if.bus_req_o}, 32'd0);
        check("drain_stall", {31'd0, stallreq_o}, 32'd0);
        check("drain_wreg", {31'd0, wreg_o}, 32'd0);
        @(posedge clk); #1;
        check("drain_req", {31'd0, bus_if.bus_req_o}, 32'd0);
        check("drain_wreg2", {31'd0, wreg_o}, 32'd0);
        bus_if.bus_ack_i = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_ack_i = 1'b0;
        aluop_i = OP_SC; mem_addr_i = 32'h20; #1;
        check("fl_llbit_sc", wdata_o, 32'd0);
        check("fl_llbit_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
        check("fl_sc_req", {31'd0, bus_if.bus_req_o}, 32'd0);
        aluop_i = NOP;
        $display("access flush op=%02h addr=%08h dropped", OP_LW, 32'h8);

        // Reset in the middle of an access.
        aluop_i = OP_SH; mem_addr_i = 32'h2; reg2_i = 32'h1234;
        @(posedge clk); #1;
        check("mrst_req_on", {31'd0, bus_if.bus_req_o}, 32'd1);
        aluop_i = NOP; rst = 1'b1; #1;
        check("mrst_req", {31'd0, bus_if.bus_req_o}, 32'd0);
        check("mrst_sel", {28'd0, bus_if.bus_sel_o}, 32'd0);
        check("mrst_wdata", bus_if.bus_wdata_o, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("mrst_idle", {31'd0, stallreq_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Clock and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  async active-high reset (`RstEnable).
REQ-004 flush  in  1  exception flush: abort current access, discard result.
REQ-005 stall  in  6  pipeline stall vector; stall[4]=1 means MEM/WB is held this cycle.
REQ-006 aluop_i  in  8  op from EX/MEM; decodes EXE_LB/LBU/LH/LHU/LW/LL/SB/SH/SW/SC_OP per defines.v; other codes are non-memory ops.
REQ-007 mem_addr_i  in  32  effective byte address.
REQ-008 reg2_i  in  32  store data (rt).
REQ-009 wd_i / wreg_i / wdata_i  in  5/1/32  destination register, write enable, ALU result.
REQ-010 wd_o / wreg_o / wdata_o  out  5/1/32  writeback fields to MEM/WB.
REQ-011 stallreq_o  out  1  request to hold IF..MEM while a bus access is pending.
REQ-012 adel_o / ades_o  out  1/1  load / store address-error flags (combinational).
REQ-013 bus_req_o / bus_we_o  out  1/1  bus request and write strobe, registered.
REQ-014 bus_addr_o  out  32  word address {mem_addr_i[31:2],2'b00}, registered.
REQ-015 bus_sel_o  out  4  byte lanes, big-endian (bit3 = bits 31:24 = byte offset 0), registered.
REQ-016 bus_wdata_o  out  32  store data replicated across lanes, registered.
REQ-017 bus_rdata_i / bus_ack_i  in  32/1  read data valid in the ack cycle; ack is one cycle wide.

Function
REQ-018 Non-memory op: wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i; no bus activity; stallreq_o=0.
REQ-019 Alignment: H ops require addr[0]=0; W/LL/SC ops require addr[1:0]=00; on violation adel_o (loads, LL) or ades_o (stores, SC)=1, wreg_o=0, no request issued, stallreq_o=0.
REQ-020 FSM states: IDLE, BUSY, HOLD, DRAIN.
REQ-021 IDLE: an aligned memory op with flush=0 and not blocked by REQ-028 raises stallreq_o combinationally; next edge loads bus_* registers with bus_req_o=1 and moves to BUSY.
REQ-022 BUSY: bus_* outputs held stable; stallreq_o = !bus_ack_i.
REQ-023 On ack in BUSY: load result is formed from bus_rdata_i in the same cycle, stallreq_o=0; next state HOLD if stall[4]=1, else IDLE; bus_req_o cleared at that edge.
REQ-024 HOLD: rdata captured at the ack edge drives the load result, stallreq_o=0, no new request; exit to IDLE when stall[4]=0.
REQ-025 Byte lanes: B sel = 1000>>addr[1:0]; H sel = 1100 for addr[1]=0, 0011 for addr[1]=1; W sel = 1111.
REQ-026 Store data: SB {4{reg2[7:0]}}, SH {2{reg2[15:0]}}, SW/SC reg2.
REQ-027 Loads: select the addressed lane; LB/LH sign-extend; LBU/LHU zero-extend; LW/LL full word; wreg_o=1 only in the result cycle, 0 while stallreq_o=1.
REQ-028 LL/SC: internal llbit set when an LL access completes; SC with llbit=1 performs a word store and writes wdata_o=1 on ack; SC with llbit=0 issues no request, wdata_o=0, wreg_o=1, no stall.
REQ-029 Flush in IDLE suppresses any request; flush in BUSY drops bus_req_o at the next edge and enters DRAIN, unless bus_ack_i=1 that cycle (then IDLE); DRAIN holds stallreq_o=0, wreg_o=0 and returns to IDLE on bus_ack_i. A flush also clears llbit.
REQ-030 A new request is never issued from BUSY, HOLD or DRAIN.

Reset
REQ-031 rst=1 forces IDLE, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_sel_o=0000, bus_wdata_o=0, llbit=0, HOLD data register=0, at any time including mid-access; combinational outputs then follow REQ-018/019.

Verification
REQ-032 LW addr 0x00000010, ack 3 cycles after request, rdata 0xDEADBEEF -> req one cycle after op, sel 1111, stallreq_o high until ack, wdata_o=0xDEADBEEF, wreg_o=1 in ack cycle.
REQ-033 LB addr 0x00000001, rdata 0x12803456 -> sel 0100, wdata_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-034 SH addr 0x00000002, reg2 0x0000BEEF -> bus_we_o=1, sel 0011, bus_wdata_o=0xBEEFBEEF.
REQ-035 LW addr 0x00000002 -> adel_o=1, bus_req_o stays 0, stallreq_o=0, wreg_o=0.
REQ-036 flush in BUSY before ack -> bus_req_o=0 next cycle, DRAIN until ack, no writeback, llbit=0.
REQ-037 SC without prior LL -> no request, wdata_o=0; LL then SC to 0x20 -> store issued, wdata_o=1 on ack.
